// File: rtl/w_full_ctrl.sv
// w_full_ctrl: write-domain pointer and flag controller for an async FIFO.
// Keeps the binary write pointer and its registered Gray image for CDC. From
// the synchronised read pointer it derives full, almost-full, fill level and
// a sticky overflow flag. Every flag is computed from the *next* write
// pointer, so full asserts on the same edge that commits the last write.
module w_full_ctrl #(
   parameter int ADDR_WIDTH   = 3,
   parameter int AFULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  wrst,
   input  logic                  wen,
   input  logic                  wovf_clr,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   output logic [ADDR_WIDTH:0]   wptr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  wwrite,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  wovf
);

   localparam int A = ADDR_WIDTH;
   // The threshold is at most 2**A, so it fits in the A+1-bit level domain.
   localparam logic [A:0] AFULL_TH = AFULL_THRESH[A:0];

   logic [A:0] wbin;
   logic [A:0] wbinnext;
   logic [A:0] wgraynext;
   logic [A:0] rbin_sync;
   logic [A:0] level_next;
   logic [A:0] full_pattern;
   logic       overflow;

   // A write is only committed while there is room.
   assign wwrite   = wen & ~wfull;
   assign waddr    = wbin[A-1:0];
   assign overflow = wen & wfull;

   assign wbinnext  = wbin + {{A{1'b0}}, wwrite};
   assign wgraynext = wbinnext ^ (wbinnext >> 1);

   // Gray-to-binary conversion of the synchronised read pointer: each binary
   // bit is the XOR of all Gray bits from the MSB down to it.
   for (genvar i = 0; i <= A; i++) begin : g_rbin
      assign rbin_sync[i] = ^wq2_rptr[A:i];
   end

   // Full when the next write pointer is exactly one lap ahead of the read
   // pointer. In Gray code that means the two MSBs are inverted.
   assign full_pattern = {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]};

   // Fill level wraps naturally. It can only over-report, because the read
   // pointer seen here is stale.
   assign level_next = wbinnext - rbin_sync;

   // Pointer state: binary for addressing, Gray for the synchroniser.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wbin <= '0;
         wptr <= '0;
      end else begin
         wbin <= wbinnext;
         wptr <= wgraynext;
      end
   end

   // Registered status flags and level.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
      end else begin
         wfull        <= (wgraynext == full_pattern);
         walmost_full <= (level_next >= AFULL_TH);
         wlevel       <= level_next;
      end
   end

   // Sticky overflow. A new overflow takes priority over a clear.
   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst)          wovf <= 1'b0;
      else if (overflow) wovf <= 1'b1;
      else if (wovf_clr) wovf <= 1'b0;
   end

endmodule

// File: tb/tb_w_full_ctrl.sv
// tb_w_full_ctrl: directed plus randomized checks of w_full_ctrl.
// The reference model counts writes and reads as plain integers. Level is
// writes minus reads, and full means the level equals the depth.
module tb_w_full_ctrl;

   localparam int AW    = 3;
   localparam int TH    = 6;
   localparam int DEPTH = 1 << AW;

   logic          wclk = 1'b0;
   logic          wrst = 1'b1;
   logic          wen = 1'b0;
   logic          wovf_clr = 1'b0;
   logic [AW:0]   wq2_rptr = '0;
   logic [AW:0]   wptr;
   logic [AW-1:0] waddr;
   logic          wwrite;
   logic          wfull;
   logic          walmost_full;
   logic [AW:0]   wlevel;
   logic          wovf;

   w_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(TH)) dut (
      .wclk(wclk), .wrst(wrst), .wen(wen), .wovf_clr(wovf_clr),
      .wq2_rptr(wq2_rptr), .wptr(wptr), .waddr(waddr), .wwrite(wwrite),
      .wfull(wfull), .walmost_full(walmost_full), .wlevel(wlevel), .wovf(wovf)
   );

   always #5 wclk = ~wclk;

   int n_tests = 0;
   int n_fail  = 0;

   // model state
   int wc = 0;       // total accepted writes
   int rc = 0;       // total reads the write side has seen
   bit m_full = 0;
   bit m_ovf  = 0;
   bit wrapped = 0;
   logic [AW:0] prev_wptr = '0;

   function automatic logic [AW:0] to_gray(input int b);
      logic [AW:0] v;
      v = b[AW:0];
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check combinational outputs, then check the
   // registered state after the edge against the model.
   task automatic cycle(input bit en, input bit clr, input int rcount);
      bit acc;
      int lvl;
      @(negedge wclk);
      wen      = en;
      wovf_clr = clr;
      rc       = rcount;
      wq2_rptr = to_gray(rc);
      #1;
      acc = en && !m_full;
      chk("wwrite", wwrite, acc);
      chk("waddr", waddr, wc % DEPTH);
      if (en && m_full) m_ovf = 1;
      else if (clr)     m_ovf = 0;
      wc  = wc + (acc ? 1 : 0);
      lvl = wc - rc;
      m_full = (lvl == DEPTH);
      @(posedge wclk);
      #1;
      chk("wptr", wptr, to_gray(wc));
      chk("wlevel", wlevel, lvl);
      chk("wfull", wfull, m_full);
      chk("walmost_full", walmost_full, lvl >= TH);
      chk("wovf", wovf, m_ovf);
      chk("wptr_hamming", $countones(wptr ^ prev_wptr), acc ? 1 : 0);
      if (prev_wptr == 4'b1000 && wptr == 4'b0000) wrapped = 1;
      prev_wptr = wptr;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wptr"}, wptr, 0);
      chk({tag, "_wlevel"}, wlevel, 0);
      chk({tag, "_wfull"}, wfull, 0);
      chk({tag, "_walmost_full"}, walmost_full, 0);
      chk({tag, "_wovf"}, wovf, 0);
      chk({tag, "_waddr"}, waddr, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      int start_wc;

      // 1. reset state
      #12;
      chk_all_zero("reset");
      @(negedge wclk);
      wrst = 1'b0;

      // 2. fill from empty
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 0, 0);
         if (i == TH - 2) chk("fill_afull_before", walmost_full, 0);
         if (i == TH - 1) chk("fill_afull_at", walmost_full, 1);
      end
      chk("fill_wptr", wptr, 4'b1100);
      chk("fill_wlevel", wlevel, 8);
      chk("fill_waddr", waddr, 0);
      chk("fill_wfull", wfull, 1);

      // 3. overflow and sticky clear
      cycle(1, 0, 0);
      cycle(1, 0, 0);
      chk("ovf_set", wovf, 1);
      chk("ovf_wptr_held", wptr, 4'b1100);
      cycle(0, 1, 0);
      chk("ovf_clr", wovf, 0);
      cycle(1, 1, 0);
      chk("ovf_set_wins", wovf, 1);
      cycle(0, 1, 0);

      // 4. drain three slots
      cycle(0, 0, 3);
      chk("drain_wfull", wfull, 0);
      chk("drain_wlevel", wlevel, 5);
      chk("drain_afull", walmost_full, 0);

      // 5. random interleaving of writes and reads without reaching full
      start_wc = wc;
      guard = 0;
      while (wc < start_wc + 40 && guard < 1000) begin
         bit en;
         int nr;
         en = ($urandom_range(0, 3) != 0) && (wc - rc < DEPTH - 1);
         nr = rc;
         if (nr < wc && $urandom_range(0, 2) == 0) nr++;
         cycle(en, ($urandom_range(0, 7) == 0), nr);
         guard++;
      end
      chk("wrap_progress", wc >= start_wc + 40, 1);
      chk("wrap_seen", wrapped, 1);

      // 6. write and read on the same edge while full
      guard = 0;
      while (!m_full && guard < 20) begin
         cycle(1, 0, rc);
         guard++;
      end
      chk("sim_full", wfull, 1);
      cycle(1, 0, rc + 1);
      chk("sim_wfull", wfull, 0);
      chk("sim_wlevel", wlevel, 7);
      cycle(1, 0, rc);
      chk("sim_refull", wfull, 1);

      // reset asserted between edges, mid-operation
      @(negedge wclk);
      wen = 1'b1;
      #2 wrst = 1'b1;
      #1;
      chk_all_zero("midrst");
      @(posedge wclk);
      #1;
      chk_all_zero("midrst_hold");
      @(negedge wclk);
      wen = 1'b0;
      wovf_clr = 1'b0;
      wq2_rptr = '0;
      wrst = 1'b0;
      wc = 0; rc = 0; m_full = 0; m_ovf = 0; prev_wptr = '0;
      cycle(1, 0, 0);
      cycle(1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/w_full_ctrl.md
Name: w_full_ctrl

Overview:
Write-domain pointer and flag controller for the asynchronous FIFO. It is the parametrised successor of the basic write-full block. It generates the Gray-coded write pointer for CDC, the binary memory write address and the qualified memory write strobe, plus full, almost-full, fill-level and sticky-overflow status. It sits in the wclk domain, between the write client, fifo_mem and the read-to-write pointer synchroniser.

Parameters:
ADDR_WIDTH, 3, memory address width; depth = 2**ADDR_WIDTH; legal range >= 2.
AFULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.

Ports:
wclk  input  1  write-domain clock, rising edge.
wrst  input  1  asynchronous, active-high reset.
wen  input  1  client write request.
wovf_clr  input  1  clears the sticky overflow flag.
wq2_rptr  input  ADDR_WIDTH+1  read pointer, Gray code, already synchronised into wclk.
wptr  output  ADDR_WIDTH+1  registered Gray-coded write pointer, sent to the synchroniser.
waddr  output  ADDR_WIDTH  binary write address to fifo_mem.
wwrite  output  1  qualified memory write enable.
wfull  output  1  registered full flag.
walmost_full  output  1  registered almost-full flag.
wlevel  output  ADDR_WIDTH+1  registered fill level, 0..2**ADDR_WIDTH.
wovf  output  1  sticky overflow flag.

Behaviour:
- Reset (wrst=1, asynchronous, takes effect immediately):
  - wbin, wptr, wlevel = 0.
  - wfull, walmost_full, wovf = 0.
  - Reset mid-operation discards all pointer state. The read domain must also be reset.
- Combinational outputs:
  - wwrite = wen & ~wfull.
  - waddr = wbin[ADDR_WIDTH-1:0].
  - Nothing else is combinational.
- Next-state computation:
  - wbinnext = wbin + wwrite, modulo 2**(ADDR_WIDTH+1). Natural wrap, no saturation.
  - wgraynext = wbinnext ^ (wbinnext >> 1).
- Every rising wclk edge:
  - wbin <= wbinnext.
  - wptr <= wgraynext.
  - wptr is always registered Gray code. Consecutive values differ in exactly one bit.
- Full:
  - wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]}), where A = ADDR_WIDTH.
  - wfull therefore asserts on the same edge that commits the write filling the last slot. It is never one write late.
- Level:
  - rbin_sync is the Gray-to-binary conversion of wq2_rptr (XOR prefix from the MSB).
  - wlevel <= wbinnext - rbin_sync, modulo 2**(ADDR_WIDTH+1).
  - The value is pessimistic (over-estimate) because of synchroniser latency. It never under-reports.
- Almost full: walmost_full <= (wbinnext - rbin_sync) >= AFULL_THRESH.
- Overflow:
  - wovf sets on any edge where wen & wfull.
  - It stays set until an edge with wovf_clr=1 and no new overflow.
  - If overflow and wovf_clr occur on the same edge, set wins.
  - A rejected write does not change wbin, wptr or memory.
- Simultaneous events:
  - When a write and a wq2_rptr advance occur in the same cycle, both are reflected on the next edge.
  - wfull may deassert and remain deasserted if the read frees a slot.
- wq2_rptr is treated as quasi-static Gray code. No extra synchronisation is done inside this block.
- Latency: flags and level reflect a wq2_rptr change one wclk edge after it is sampled.

Test Plan:
1. Reset: assert wrst mid-clock -> immediately wptr=0, wlevel=0, wfull=0, walmost_full=0, wovf=0. Outputs hold while wrst=1.
2. Fill (ADDR_WIDTH=3, AFULL_THRESH=6, wq2_rptr=0, wen=1 for 8 cycles) ->
   - walmost_full=1 after the 6th edge.
   - After the 8th edge: wfull=1, wlevel=8, wptr=4'b1100, waddr=0.
3. Overflow: from full, wen=1 for 2 cycles ->
   - wwrite=0, and wptr/wbin unchanged.
   - wovf=1 and stays 1.
   - Pulse wovf_clr with wen=0 -> wovf=0 next edge.
   - wovf_clr together with wen=1 while full -> wovf stays 1.
4. Drain: from full, set wq2_rptr=4'b0010 (binary 3), wen=0 -> next edge wfull=0, wlevel=5, walmost_full=0.
5. Wrap: interleave writes and wq2_rptr advances over 40 writes without reaching full ->
   - wptr steps through the Gray sequence and wraps 1000->0000 (bin 15->0).
   - Hamming distance between consecutive wptr values is exactly 1.
   - wlevel matches a reference model.
6. Simultaneous: at full, wen=1 on the same edge wq2_rptr advances by 1 ->
   - The write is rejected (wfull was 1).
   - Next edge wfull=0, wlevel=7.
   - A following write is accepted and re-asserts wfull.
